// File: rtl/uart_arb_pkg.sv
// Shared state encoding and parameter defaults for the UART TX arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } arb_state_t;

   localparam int DATA_W_DEF       = 8;
   localparam int LOCK_TIMEOUT_DEF = 1000000;

   // Smallest width whose range strictly exceeds the timeout value.
   function automatic int cnt_w_for(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_lock_timer.sv
// Silence timer for the granted requester; pulses expire on the LOCK_TIMEOUT-th
// consecutive enabled cycle since the last clear.
module lock_timer #(
   parameter int LOCK_TIMEOUT = 1000000,
   parameter int CNT_W        = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic hold,
   output logic expire
);

   // Counts down the silent cycles still allowed; zero is the terminal count.
   localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

   logic [CNT_W-1:0] remain_q;
   logic             step;

   assign step   = enable && !hold && !clear;
   assign expire = step && (remain_q == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         remain_q <= TC_LOAD;
      end else if (clear) begin
         remain_q <= TC_LOAD;
      end else if (step && (remain_q != '0)) begin
         remain_q <= remain_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX channel between the
// debug port response stream (req0) and the Brainfuck core output (req1).
//
// state     | meaning
// ST_IDLE   | no owner; picks a requester for the next cycle
// ST_GRANT0 | req0 owns the channel until its last byte or a timeout
// ST_GRANT1 | req1 owns the channel until its last byte or a timeout
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
   parameter int CNT_W        = cnt_w_for(LOCK_TIMEOUT)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_req0_valid,
   input  logic [DATA_W-1:0] io_req0_bits,
   input  logic              io_req0_last,
   output logic              io_req0_ready,
   input  logic              io_req1_valid,
   input  logic [DATA_W-1:0] io_req1_bits,
   input  logic              io_req1_last,
   output logic              io_req1_ready,
   output logic              io_tx_valid,
   output logic [DATA_W-1:0] io_tx_bits,
   input  logic              io_tx_ready,
   output logic [1:0]        io_grant,
   output logic [7:0]        io_timeoutCount
);

   arb_state_t state_q;
   logic       rr_q;
   logic       granted;
   logic       own_valid;
   logic       own_last;
   logic       xfer;
   logic       expire;

   always_comb begin
      io_tx_valid   = 1'b0;
      io_tx_bits    = '0;
      io_req0_ready = 1'b0;
      io_req1_ready = 1'b0;
      own_valid     = 1'b0;
      own_last      = 1'b0;
      case (state_q)
         ST_GRANT0: begin
            io_tx_valid   = io_req0_valid;
            io_tx_bits    = io_req0_bits;
            io_req0_ready = io_tx_ready;
            own_valid     = io_req0_valid;
            own_last      = io_req0_last;
         end
         ST_GRANT1: begin
            io_tx_valid   = io_req1_valid;
            io_tx_bits    = io_req1_bits;
            io_req1_ready = io_tx_ready;
            own_valid     = io_req1_valid;
            own_last      = io_req1_last;
         end
         default: ;
      endcase
   end

   assign granted = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
   assign xfer    = io_tx_valid && io_tx_ready;

   // Backpressure with data pending freezes the timer rather than counting.
   lock_timer #(
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_lock_timer (
      .clock (clock),
      .reset (reset),
      .clear (!granted || xfer),
      .enable(granted && !own_valid),
      .hold  (own_valid && !io_tx_ready),
      .expire(expire)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         rr_q            <= 1'b0;
         io_grant        <= 2'b00;
         io_timeoutCount <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (io_req0_valid && (!io_req1_valid || !rr_q)) begin
                  state_q  <= ST_GRANT0;
                  io_grant <= 2'b01;
               end else if (io_req1_valid) begin
                  state_q  <= ST_GRANT1;
                  io_grant <= 2'b10;
               end
            end
            ST_GRANT0, ST_GRANT1: begin
               if ((xfer && own_last) || expire) begin
                  state_q  <= ST_IDLE;
                  io_grant <= 2'b00;
                  rr_q     <= (state_q == ST_GRANT0);
                  if (expire && (io_timeoutCount != 8'hFF)) begin
                     io_timeoutCount <= io_timeoutCount + 8'd1;
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               io_grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all
// checked every cycle against an owner/queue-level reference model.
module tb_uart_tx_arbiter;

   localparam int LT = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       rv [2];
   logic [7:0] rb [2];
   logic       rl [2];
   logic       tx_rdy;

   logic       io_req0_ready, io_req1_ready, io_tx_valid;
   logic [7:0] io_tx_bits;
   logic [1:0] io_grant;
   logic [7:0] io_timeoutCount;

   always #5 clock = ~clock;

   uart_tx_arbiter #(.DATA_W(8), .LOCK_TIMEOUT(LT)) dut (
      .clock          (clock),
      .reset          (reset),
      .io_req0_valid  (rv[0]),
      .io_req0_bits   (rb[0]),
      .io_req0_last   (rl[0]),
      .io_req0_ready  (io_req0_ready),
      .io_req1_valid  (rv[1]),
      .io_req1_bits   (rb[1]),
      .io_req1_last   (rl[1]),
      .io_req1_ready  (io_req1_ready),
      .io_tx_valid    (io_tx_valid),
      .io_tx_bits     (io_tx_bits),
      .io_tx_ready    (tx_rdy),
      .io_grant       (io_grant),
      .io_timeoutCount(io_timeoutCount)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Pending bytes per requester: {last, byte}.
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic       pres  [2];
   int         stall [2];
   int         gap_rate  = 0;
   bit         rand_mode = 1'b0;

   logic [7:0] tx_log  [$];
   logic [1:0] gnt_log [$];
   int         cyc_log [$];

   // Reference model: owner is -1 when nobody holds the channel.
   int m_owner, m_rr, m_silent, m_tmo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = -1;
      m_rr     = 0;
      m_silent = 0;
      m_tmo    = 0;
   endtask

   task automatic model_step(output logic acc0, output logic acc1);
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (m_owner < 0) begin
         m_silent = 0;
         if (rv[0] && (!rv[1] || m_rr == 0)) m_owner = 0;
         else if (rv[1]) m_owner = 1;
      end else if (rv[m_owner] && tx_rdy) begin
         if (m_owner == 0) acc0 = 1'b1; else acc1 = 1'b1;
         m_silent = 0;
         if (rl[m_owner]) begin
            m_rr    = 1 - m_owner;
            m_owner = -1;
         end
      end else if (!rv[m_owner]) begin
         m_silent++;
         if (m_silent == LT) begin
            if (m_tmo < 255) m_tmo++;
            m_rr    = 1 - m_owner;
            m_owner = -1;
         end
      end
   endtask

   task automatic drive_inputs();
      if (rand_mode) tx_rdy = (int'($urandom_range(99)) < 70);
      for (int k = 0; k < 2; k++) begin
         int         sz;
         logic [8:0] hd;
         sz = (k == 0) ? q0.size() : q1.size();
         hd = 9'h0;
         if (sz > 0) hd = (k == 0) ? q0[0] : q1[0];
         if (!pres[k] && sz > 0) begin
            if (stall[k] > 0) stall[k]--;
            else if (int'($urandom_range(99)) >= gap_rate) pres[k] = 1'b1;
         end
         if (pres[k]) begin
            rv[k] = 1'b1;
            rb[k] = hd[7:0];
            rl[k] = hd[8];
         end else begin
            rv[k] = 1'b0;
            rb[k] = 8'($urandom);
            rl[k] = 1'($urandom);
         end
      end
   endtask

   task automatic tick();
      logic [1:0] eg;
      logic       ev, er0, er1, a0, a1, lst;
      logic [7:0] eb;
      drive_inputs();
      #1;
      eg = 2'b00; ev = 1'b0; eb = 8'h00; er0 = 1'b0; er1 = 1'b0;
      if (m_owner == 0) begin
         eg = 2'b01; ev = rv[0]; eb = rb[0]; er0 = tx_rdy;
      end else if (m_owner == 1) begin
         eg = 2'b10; ev = rv[1]; eb = rb[1]; er1 = tx_rdy;
      end
      chk("outs{grant,valid,bits,rdy0,rdy1}",
          32'({io_grant, io_tx_valid, io_tx_bits, io_req0_ready, io_req1_ready}),
          32'({eg, ev, eb, er0, er1}));
      chk("timeout_count", 32'(io_timeoutCount), 32'(m_tmo));
      if (io_tx_valid && tx_rdy) begin
         tx_log.push_back(io_tx_bits);
         gnt_log.push_back(io_grant);
         cyc_log.push_back(cyc);
      end
      model_step(a0, a1);
      @(posedge clock);
      if (a0 && q0.size() > 0) begin
         lst = q0[0][8];
         void'(q0.pop_front());
         pres[0] = 1'b0;
         if (rand_mode && !lst && $urandom_range(99) < 8) stall[0] = $urandom_range(24, 12);
      end
      if (a1 && q1.size() > 0) begin
         lst = q1[0][8];
         void'(q1.pop_front());
         pres[1] = 1'b0;
         if (rand_mode && !lst && $urandom_range(99) < 8) stall[1] = $urandom_range(24, 12);
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) @(negedge clock);
      q0.delete();
      q1.delete();
      pres[0] = 1'b0; pres[1] = 1'b0;
      stall[0] = 0;   stall[1] = 0;
      model_reset();
      reset = 1'b1;
   endtask

   task automatic drain(input string tag, input int bound);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0) && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < bound), 32'd1);
   endtask

   task automatic clear_logs();
      tx_log.delete();
      gnt_log.delete();
      cyc_log.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_grant"},    32'(io_grant), 32'd0);
      chk({tag, "_tx_valid"}, 32'(io_tx_valid), 32'd0);
      chk({tag, "_ready0"},   32'(io_req0_ready), 32'd0);
      chk({tag, "_ready1"},   32'(io_req1_ready), 32'd0);
      chk({tag, "_tmo"},      32'(io_timeoutCount), 32'd0);
   endtask

   initial begin
      int start, tc, n, own, idx;
      reset  = 1'b0;
      tx_rdy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rv[k] = 1'b0; rb[k] = 8'h00; rl[k] = 1'b0; pres[k] = 1'b0; stall[k] = 0;
      end
      model_reset();

      // Reset held for 5 cycles, then released.
      do_reset(5);
      #1;
      check_reset_outputs("reset");
      @(negedge clock);
      tick();

      // Single 3-byte packet from req0.
      clear_logs();
      q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h143);
      start = cyc;
      drain("single_drain", 50);
      chk("single_count", 32'(tx_log.size()), 32'd3);
      for (int j = 0; j < 3 && j < tx_log.size(); j++)
         chk("single_byte", 32'(tx_log[j]), 32'(8'h41 + j));
      if (cyc_log.size() == 3) begin
         chk("single_latency", 32'(cyc_log[0] - start), 32'd1);
         chk("single_consec1", 32'(cyc_log[1] - cyc_log[0]), 32'd1);
         chk("single_consec2", 32'(cyc_log[2] - cyc_log[1]), 32'd1);
      end
      chk("single_idle_after", 32'(io_grant), 32'd0);

      // Contention: three 2-byte packets each, starting with rr at req0.
      do_reset(2);
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         q0.push_back({1'b0, 8'(8'h10 + 2 * i)}); q0.push_back({1'b1, 8'(8'h11 + 2 * i)});
         q1.push_back({1'b0, 8'(8'h20 + 2 * i)}); q1.push_back({1'b1, 8'(8'h21 + 2 * i)});
      end
      drain("contend_drain", 200);
      chk("contend_count", 32'(tx_log.size()), 32'd12);
      for (int j = 0; j < 12 && j < tx_log.size(); j++) begin
         own = (j / 2) % 2;
         idx = (j / 4) * 2 + (j % 2);
         chk("contend_byte", 32'(tx_log[j]), 32'((own == 1 ? 8'h20 : 8'h10) + idx));
         chk("contend_grant", 32'(gnt_log[j]), 32'(own == 1 ? 2'b10 : 2'b01));
      end

      // Backpressure on req1 for far longer than the lock timeout.
      clear_logs();
      q1.push_back(9'h0A0); q1.push_back(9'h0A1); q1.push_back(9'h1A2);
      n = 0;
      while (tx_log.size() < 1 && n < 20) begin tick(); n++; end
      tx_rdy = 1'b0;
      repeat (2000) tick();
      chk("bp_grant", 32'(io_grant), 32'd2);
      chk("bp_tmo", 32'(io_timeoutCount), 32'd0);
      tx_rdy = 1'b1;
      drain("bp_drain", 50);
      chk("bp_count", 32'(tx_log.size()), 32'd3);

      // Timeout: req0 sends one non-last byte then goes silent.
      clear_logs();
      q0.push_back(9'h055);
      n = 0;
      while (tx_log.size() < 1 && n < 20) begin tick(); n++; end
      tc = (cyc_log.size() > 0) ? cyc_log[0] : cyc;
      q1.push_back(9'h166);
      n = 0;
      while (io_grant == 2'b01 && n < 100) begin tick(); n++; end
      // Transfer edge ends cycle tc; 16 silent cycles follow; idle is seen one cycle later.
      chk("tmo_release_delay", 32'(cyc - tc), 32'(LT + 1));
      chk("tmo_count", 32'(io_timeoutCount), 32'd1);
      tick();
      chk("tmo_next_grant", 32'(io_grant), 32'd2);
      drain("tmo_drain", 50);

      // Reset in the middle of a 4-byte req0 packet.
      clear_logs();
      q0.push_back(9'h030); q0.push_back(9'h031); q0.push_back(9'h032); q0.push_back(9'h133);
      n = 0;
      while (tx_log.size() < 2 && n < 20) begin tick(); n++; end
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      do_reset(2);
      clear_logs();
      q0.push_back(9'h070); q0.push_back(9'h071); q0.push_back(9'h072); q0.push_back(9'h173);
      q1.push_back(9'h07A); q1.push_back(9'h17B);
      drain("midrst_drain", 50);
      chk("midrst_count", 32'(tx_log.size()), 32'd6);
      for (int j = 0; j < 4 && j < tx_log.size(); j++) begin
         chk("midrst_byte", 32'(tx_log[j]), 32'(8'h70 + j));
         chk("midrst_grant", 32'(gnt_log[j]), 32'd1);
      end

      // Random traffic with gaps, stalls and downstream backpressure.
      clear_logs();
      rand_mode = 1'b1;
      gap_rate  = 30;
      for (int p = 0; p < 40; p++) begin
         int len0, len1;
         len0 = $urandom_range(4, 1);
         len1 = $urandom_range(4, 1);
         for (int b = 0; b < len0; b++) q0.push_back({b == len0 - 1, 8'($urandom)});
         for (int b = 0; b < len1; b++) q1.push_back({b == len1 - 1, 8'($urandom)});
      end
      drain("random_drain", 20000);
      rand_mode = 1'b0;
      gap_rate  = 0;
      tx_rdy    = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel between two byte-stream requesters.
- Requester 0 is the debug access port's response stream; requester 1 is the Brainfuck core's program output ('.' bytes).
- Grants are packet-locked (held until a `last` byte) and round-robin between packets.
- A lock timer stops a stalled requester from holding the UART indefinitely.
- Sits between the requesters and the UART TX serializer, in the same clock domain as the rest of the design.

Parameters:
- DATA_W, 8, byte width of the streams.
- LOCK_TIMEOUT, 1000000, idle cycles (10 ms at 100 MHz) a granted requester may stay silent before forced release.
- CNT_W, 20, width of the lock timer; must satisfy 2^CNT_W > LOCK_TIMEOUT.

Ports:
- clock  in  1  system clock; all logic is in this single clock domain.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_req0_valid  in  1  requester 0 has a byte.
- io_req0_bits  in  DATA_W  requester 0 byte.
- io_req0_last  in  1  requester 0 byte is the final byte of its packet.
- io_req0_ready  out  1  requester 0 byte accepted this cycle.
- io_req1_valid, io_req1_bits, io_req1_last, io_req1_ready: same meaning, for requester 1.
- io_tx_valid  out  1  byte offered to the UART TX.
- io_tx_bits  out  DATA_W  byte to the UART TX.
- io_tx_ready  in  1  UART TX accepts the byte.
- io_grant  out  2  one-hot current owner; 00 when idle.
- io_timeoutCount  out  8  number of forced releases, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr pointer=0 (requester 0 preferred), lock timer=0, io_timeoutCount=0.
  - io_grant=00, io_tx_valid=0, both ready outputs 0.
  - Reset asserted mid-packet abandons the packet; no byte is emitted or accepted while reset is low.
- A transfer occurs when io_tx_valid && io_tx_ready. It is the only event that consumes a requester byte.
- States: IDLE, GRANT0, GRANT1. The state is registered, and io_grant is decoded from it (GRANT0=01, GRANT1=10).
- IDLE:
  - io_tx_valid=0, io_tx_bits=0, both ready outputs 0.
  - If only one requester is valid, go to its GRANT state.
  - If both are valid, grant the one the rr pointer selects.
  - Grant latency is 1 cycle: no byte passes in the cycle the request is first seen.
- GRANTk:
  - Combinational pass-through: io_tx_valid=io_reqk_valid, io_tx_bits=io_reqk_bits, io_reqk_ready=io_tx_ready.
  - The other requester's ready is 0.
- Packet end: a transfer with io_reqk_last=1 moves GRANTk -> IDLE and sets the rr pointer to the other requester.
- Back-to-back packets: after returning to IDLE, the next grant is taken the following cycle, so there is a minimum 1-cycle bubble between packets.
- Lock timer (active in GRANTk only):
  - Cleared on every transfer and on entry to GRANTk.
  - Increments on cycles where io_reqk_valid=0.
  - Holds its value while io_reqk_valid=1 and io_tx_ready=0; downstream backpressure never counts against the requester.
- Forced release:
  - Triggers when the timer equals LOCK_TIMEOUT-1 and increments on that cycle.
  - Next state is IDLE, the rr pointer flips to the other requester, and io_timeoutCount increments (saturating at 255).
  - The partial packet is not flushed; later bytes from that requester start a new arbitration.
- A transfer and a timeout cannot coincide, because the timer only increments when valid=0.
- Requesters must hold valid, bits and last stable until ready. The arbiter does not check this.
- A byte with last=1 in a 1-byte packet is legal: grant, one transfer, then back to IDLE.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2);
  - DATA_W default;
  - LOCK_TIMEOUT default;
  - a CNT_W derivation helper (clog2).
- One sub-module, lock_timer, is natural. It is a CNT_W counter:
  - inputs: clear, enable, hold;
  - output: a one-cycle expire pulse at LOCK_TIMEOUT-1.

Test Plan:
- Reset then idle: hold reset=0 for 5 cycles, then release -> io_grant=00, io_tx_valid=0, io_timeoutCount=0, both ready outputs 0.
- Single packet from req0: bytes 0x41,0x42,0x43 (last on 0x43), io_tx_ready=1 -> io_grant=01 one cycle after valid; tx sees exactly 41,42,43 on consecutive cycles; IDLE the cycle after the transfer of 0x43.
- Contention with round-robin: both valid at once, each sending a 2-byte packet, repeated 3 times:
  - with rr=0 the order is req0, req1, req0, req1, req0, req1;
  - no interleaving of bytes within a packet.
- Backpressure: during req1's packet hold io_tx_ready=0 for 2,000,000 cycles with io_req1_valid=1 -> no timeout; grant stays 10; io_timeoutCount=0.
- Timeout: with LOCK_TIMEOUT=16, req0 sends 1 non-last byte then drops valid -> forced release exactly 16 cycles after that transfer; io_timeoutCount=1; a pending req1 is granted next.
- Reset mid-packet: assert reset=0 after the 2nd of 4 bytes -> all outputs return to reset values immediately (asynchronously); after release, the rr pointer is 0 and a new req0 packet transmits from its first byte.
